// File: rtl/axi_master_pkg.sv
// Shared encodings, state enum and constants for the AXI4 write/read-back burst master.
package axi_master_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam int BOUNDARY_4K = 4096;

    // AXI AxSIZE encoding for a bus of the given byte width.
    function automatic logic [2:0] size_enc(input int bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// AXI4 five-channel bundle between the burst master and its slave/interconnect.
interface axi_burst_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    // Every channel transfers on a cycle where valid and ready are both high at the
    // rising clock edge; a source holds valid and its payload stable until that edge.
    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_burst_beat_counter.sv
// Loadable 8-bit beat counter; last is high while the count sits on the terminal beat.
module axi_burst_beat_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] len,
    input  logic       inc,
    output logic       last
);

    logic [7:0] count;
    logic [7:0] term;

    // Saturates on the terminal beat so overlong bursts keep reporting last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
            term  <= 8'd0;
        end else if (load) begin
            count <= 8'd0;
            term  <= len;
        end else if (inc && !last) begin
            count <= count + 8'd1;
        end
    end

    assign last = (count == term);

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 master: per command writes an incrementing burst, reads it back and streams the read data out.
module axi_burst_master
    import axi_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int TXN_ID     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [DATA_WIDTH-1:0] data_seed,
    output logic                  busy,
    output logic                  interrupt,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output state_t                dbg_state,
    axi_burst_master_if.master    m_axi
);

    localparam int            BYTES    = DATA_WIDTH / 8;
    localparam logic [2:0]    SIZE     = size_enc(BYTES);
    localparam logic [ID_WIDTH-1:0] ID = ID_WIDTH'(TXN_ID);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  overrun_q;

    logic                  awvalid, wvalid, bready, arvalid, rready;
    logic [ID_WIDTH-1:0]   awid, arid;
    logic [ADDR_WIDTH-1:0] awaddr, araddr;
    logic [7:0]            awlen, arlen;
    logic [2:0]            awsize, arsize;
    logic [1:0]            awburst, arburst;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BYTES-1:0]      wstrb;
    logic                  wlast;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic w_last, r_last;
    logic accept, cmd_bad, misaligned;
    logic [13:0] span_end;

    assign aw_hs = awvalid && m_axi.awready;
    assign w_hs  = wvalid  && m_axi.wready;
    assign b_hs  = bready  && m_axi.bvalid;
    assign ar_hs = arvalid && m_axi.arready;
    assign r_hs  = rready  && m_axi.rvalid;

    // First byte past the burst, relative to its 4 KB page.
    assign span_end   = {2'b00, cmd_addr[11:0]} + ((14'(cmd_len) + 14'd1) << SIZE);
    assign misaligned = |(cmd_addr & ADDR_WIDTH'(BYTES - 1));
    assign cmd_bad    = misaligned || (span_end > 14'(BOUNDARY_4K));
    assign accept     = (state == ST_IDLE) && start;

    axi_burst_beat_counter u_w_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .len   (cmd_len),
        .inc   (w_hs),
        .last  (w_last)
    );

    axi_burst_beat_counter u_r_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .len   (cmd_len),
        .inc   (r_hs),
        .last  (r_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept && !cmd_bad)         state_next = ST_AW;
            ST_AW:   if (aw_hs)                      state_next = ST_W;
            ST_W:    if (w_hs && w_last)             state_next = ST_B;
            ST_B:    if (b_hs)                       state_next = ST_AR;
            ST_AR:   if (ar_hs)                      state_next = ST_R;
            ST_R:    if (r_hs && m_axi.rlast)        state_next = ST_DONE;
            ST_DONE:                                 state_next = ST_IDLE;
            default:                                 state_next = ST_IDLE;
        endcase
    end

    // Channel payloads are zeroed outside their own state so reset leaves the bus quiet.
    always_comb begin
        awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        wvalid  = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        bready  = 1'b0;
        arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        rready  = 1'b0;
        busy    = (state != ST_IDLE) && (state != ST_DONE);
        case (state)
            ST_AW: begin
                awvalid = 1'b1; awid = ID; awaddr = addr_q; awlen = len_q;
                awsize = SIZE; awburst = BURST_INCR;
            end
            ST_W: begin
                wvalid = 1'b1; wdata = wdata_q; wstrb = '1; wlast = w_last;
            end
            ST_B:  bready = 1'b1;
            ST_AR: begin
                arvalid = 1'b1; arid = ID; araddr = addr_q; arlen = len_q;
                arsize = SIZE; arburst = BURST_INCR;
            end
            ST_R:  rready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            len_q     <= '0;
            wdata_q   <= '0;
            overrun_q <= 1'b0;
            interrupt <= 1'b0;
            error     <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= r_hs && !overrun_q;
            if (accept) begin
                addr_q    <= cmd_addr;
                len_q     <= cmd_len;
                wdata_q   <= data_seed;
                overrun_q <= 1'b0;
                interrupt <= cmd_bad;
                error     <= cmd_bad;
            end
            if (w_hs) wdata_q <= wdata_q + DATA_WIDTH'(1);
            if (b_hs && ((m_axi.bresp != RESP_OKAY) || (m_axi.bid != ID))) error <= 1'b1;
            if (r_hs) begin
                if ((m_axi.rresp != RESP_OKAY) || (m_axi.rid != ID) || (m_axi.rlast != r_last))
                    error <= 1'b1;
                // Beats beyond the terminal one are drained but never forwarded.
                if (r_last && !m_axi.rlast) overrun_q <= 1'b1;
                if (!overrun_q) rd_data <= m_axi.rdata;
                if (m_axi.rlast) interrupt <= 1'b1;
            end
        end
    end

    assign dbg_state = state;

    assign m_axi.awvalid = awvalid;
    assign m_axi.awid    = awid;
    assign m_axi.awaddr  = awaddr;
    assign m_axi.awlen   = awlen;
    assign m_axi.awsize  = awsize;
    assign m_axi.awburst = awburst;
    assign m_axi.wvalid  = wvalid;
    assign m_axi.wdata   = wdata;
    assign m_axi.wstrb   = wstrb;
    assign m_axi.wlast   = wlast;
    assign m_axi.bready  = bready;
    assign m_axi.arvalid = arvalid;
    assign m_axi.arid    = arid;
    assign m_axi.araddr  = araddr;
    assign m_axi.arlen   = arlen;
    assign m_axi.arsize  = arsize;
    assign m_axi.arburst = arburst;
    assign m_axi.rready  = rready;

endmodule
